// File: rtl/flash_stream_if.sv
// SPI-flash slave signal bundle: serial pins, error flag and word-fetch port.
// Latency: none (wires only).
// Backpressure: none; rd_dat must be valid in the same cycle rd_vld/rd_addr are driven.
interface flash_stream_if;
    logic        mosi;
    logic        miso;
    logic        cmd_err;
    logic        rd_vld;
    logic [31:0] rd_addr;
    logic [31:0] rd_dat;

    // Host/flash-array side: drives serial input and answers word fetches
    modport master (output mosi, output rd_dat, input miso, input cmd_err, input rd_vld, input rd_addr);
    // Flash slave side
    modport slave  (input mosi, input rd_dat, output miso, output cmd_err, output rd_vld, output rd_addr);
endinterface

// File: rtl/flash_stream.sv
// SPI NOR flash read slave (03h read, 9Fh JEDEC ID, 05h status; 0Bh fast read when FLASH_FAST_READ_EN is defined).
// Latency: first data bit on miso right after the posedge that samples the last address/dummy bit; no gaps while streaming.
// Backpressure: none; the word array is read combinationally through rd_vld/rd_addr/rd_dat on each fetching posedge.
module flash_stream #(
    parameter int          ADDR_BYTES   = 3,
    parameter int          SIZE_LOG2    = 24,
    parameter int          DUMMY_CYCLES = 8,
    parameter logic [23:0] JEDEC_ID     = 24'hEF4018
) (
    input  logic         clock,
    input  logic         reset,
    flash_stream_if.slave bus
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam logic [31:0] SIZE_MASK = (SIZE_LOG2 >= 32) ? 32'hFFFF_FFFF
                                                          : ((32'd1 << SIZE_LOG2) - 32'd1);
    localparam logic [31:0] WORD_MASK = SIZE_MASK & 32'hFFFF_FFFC;

`ifdef FLASH_FAST_READ_EN
    typedef enum logic [2:0] {
        S_CMD = 3'd0, S_ADDR = 3'd1, S_DUMMY = 3'd2, S_DATA = 3'd3,
        S_ID = 3'd4, S_STATUS = 3'd5, S_ERR = 3'd6
    } state_t;
    localparam int DW = (DUMMY_CYCLES > 1) ? $clog2(DUMMY_CYCLES) : 1;
    logic [DW-1:0] dummy_cnt_q, dummy_cnt_d;
`else
    typedef enum logic [2:0] {
        S_CMD = 3'd0, S_ADDR = 3'd1, S_DATA = 3'd3,
        S_ID = 3'd4, S_STATUS = 3'd5, S_ERR = 3'd6
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [7:0]  opcode_q, opcode_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] word_q, word_d;
    logic [1:0]  byte_q, byte_d;
    logic [2:0]  bit_q, bit_d;

    logic        fetch;
    logic [31:0] fetch_addr;
    logic [7:0]  op_shift;
    logic [31:0] addr_shift;
    logic [7:0]  id_byte;
    logic        miso_c;

    // State register; SS high clears everything asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_CMD;
            cnt_q       <= '0;
            opcode_q    <= '0;
            addr_q      <= '0;
            word_q      <= '0;
            byte_q      <= '0;
            bit_q       <= '0;
`ifdef FLASH_FAST_READ_EN
            dummy_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opcode_q    <= opcode_d;
            addr_q      <= addr_d;
            word_q      <= word_d;
            byte_q      <= byte_d;
            bit_q       <= bit_d;
`ifdef FLASH_FAST_READ_EN
            dummy_cnt_q <= dummy_cnt_d;
`endif
        end
    end

    // Next-state, shift registers and word-fetch request
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opcode_d   = opcode_q;
        addr_d     = addr_q;
        word_d     = word_q;
        byte_d     = byte_q;
        bit_d      = bit_q;
        fetch      = 1'b0;
        fetch_addr = addr_q;
        op_shift   = {opcode_q[6:0], bus.mosi};
        addr_shift = {addr_q[30:0], bus.mosi};
`ifdef FLASH_FAST_READ_EN
        dummy_cnt_d = dummy_cnt_q;
`endif
        case (state_q)
            S_CMD: begin
                opcode_d = op_shift;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == 6'd7) begin
                    cnt_d  = '0;
                    bit_d  = 3'd7;
                    byte_d = 2'd0;
                    case (op_shift)
                        8'h03:   state_d = S_ADDR;
`ifdef FLASH_FAST_READ_EN
                        8'h0B:   state_d = S_ADDR;
`endif
                        8'h9F:   state_d = S_ID;
                        8'h05:   state_d = S_STATUS;
                        default: state_d = S_ERR;
                    endcase
                end
            end
            S_ADDR: begin
                addr_d = addr_shift;
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'(AW - 1)) begin
                    cnt_d = '0;
`ifdef FLASH_FAST_READ_EN
                    if (opcode_q == 8'h0B && DUMMY_CYCLES != 0) begin
                        state_d = S_DUMMY;
                    end else begin
                        fetch      = 1'b1;
                        fetch_addr = addr_shift;
                    end
`else
                    fetch      = 1'b1;
                    fetch_addr = addr_shift;
`endif
                end
            end
`ifdef FLASH_FAST_READ_EN
            S_DUMMY: begin
                dummy_cnt_d = dummy_cnt_q + 1'b1;
                if (dummy_cnt_q == DW'(DUMMY_CYCLES - 1)) begin
                    dummy_cnt_d = '0;
                    fetch       = 1'b1;
                    fetch_addr  = addr_q;
                end
            end
`endif
            S_DATA: begin
                bit_d = bit_q - 3'd1;
                if (bit_q == 3'd0) begin
                    if (byte_q == 2'd3) begin
                        fetch      = 1'b1;
                        fetch_addr = addr_q + 32'd4;
                    end else begin
                        byte_d = byte_q + 2'd1;
                    end
                end
            end
            S_ID: begin
                bit_d = bit_q - 3'd1;
                if (bit_q == 3'd0 && byte_q != 2'd3) byte_d = byte_q + 2'd1;
            end
            default: ;
        endcase

        // A fetch loads the word and starts at the requested byte; streaming fetches are aligned so start at byte 0
        if (fetch) begin
            state_d = S_DATA;
            addr_d  = fetch_addr & WORD_MASK;
            word_d  = bus.rd_dat;
            byte_d  = fetch_addr[1:0];
            bit_d   = 3'd7;
        end
    end

    // Serial output selection; idle and error states hold the line high
    always_comb begin
        case (byte_q)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'hFF;
        endcase
        case (state_q)
            S_DATA:   miso_c = word_q[{byte_q, bit_q}];
            S_ID:     miso_c = id_byte[bit_q];
            S_STATUS: miso_c = 1'b0;
            default:  miso_c = 1'b1;
        endcase
        if (reset) miso_c = 1'b1;
    end

    assign bus.miso    = miso_c;
    assign bus.cmd_err = (state_q == S_ERR);
    assign bus.rd_vld  = fetch;
    assign bus.rd_addr = fetch_addr & WORD_MASK;
endmodule

// File: tb/tb_flash_stream.sv
// Directed bench for flash_stream: reads, wrap, fast read, ID, status, errors and SS-reset.
// Latency: mosi driven at negedge, miso sampled at negedge (half a clock after the DUT posedge).
// Backpressure: n/a; the word array answers fetches combinationally.
module tb_flash_stream;
    logic clock;
    logic reset;
    int   n_pass;
    int   n_total;
    logic [31:0] fetch_q[$];

    flash_stream_if bus();

    flash_stream #(
        .ADDR_BYTES(3), .SIZE_LOG2(24), .DUMMY_CYCLES(8), .JEDEC_ID(24'hEF4018)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Flash contents: word 0 is 44332211, elsewhere the byte at address A is A[7:0]
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'h44332211;
        return {a[7:0] + 8'd3, a[7:0] + 8'd2, a[7:0] + 8'd1, a[7:0]};
    endfunction

    always_comb bus.rd_dat = mem_word(bus.rd_addr);

    // Log every word fetch the DUT performs
    always @(posedge clock) begin
        if (!reset && bus.rd_vld === 1'b1) fetch_q.push_back(bus.rd_addr);
    end

    // All tasks are entered and left just after a negedge
    task automatic start_txn();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        fetch_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            bus.mosi = b[i];
            @(negedge clock);
        end
    endtask

    task automatic send_addr(input logic [23:0] a);
        send_byte(a[23:16]);
        send_byte(a[15:8]);
        send_byte(a[7:0]);
    endtask

    task automatic read_byte(output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            b[i] = bus.miso;
            bus.mosi = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.mosi = 1'b0;
        @(negedge clock);
        n_total++;
        if (bus.miso !== 1'b1) $display("FAIL reset_miso got %b want 1", bus.miso);
        else n_pass++;
        n_total++;
        if (bus.cmd_err !== 1'b0) $display("FAIL reset_cmd_err got %b want 0", bus.cmd_err);
        else n_pass++;
    endtask

    task automatic test_read_aligned();
        logic [7:0] exp [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h04, 8'h05};
        logic [7:0] b;
        start_txn();
        send_byte(8'h03);
        send_addr(24'h000000);
        for (int k = 0; k < 6; k++) begin
            read_byte(b);
            n_total++;
            if (b !== exp[k]) $display("FAIL read0_byte%0d got %h want %h", k, b, exp[k]);
            else n_pass++;
        end
        n_total++;
        if (fetch_q.size() !== 2) $display("FAIL read0_nfetch got %0d want 2", fetch_q.size());
        else n_pass++;
        n_total++;
        if (fetch_q.size() < 1 || fetch_q[0] !== 32'h0) $display("FAIL read0_fetch0 got %h want 00000000", fetch_q.size() > 0 ? fetch_q[0] : 32'hx);
        else n_pass++;
        n_total++;
        if (fetch_q.size() < 2 || fetch_q[1] !== 32'h4) $display("FAIL read0_fetch1 got %h want 00000004", fetch_q.size() > 1 ? fetch_q[1] : 32'hx);
        else n_pass++;
    endtask

    task automatic test_read_unaligned();
        logic [7:0] exp [3] = '{8'h33, 8'h44, 8'h04};
        logic [7:0] b;
        start_txn();
        send_byte(8'h03);
        send_addr(24'h000002);
        for (int k = 0; k < 3; k++) begin
            read_byte(b);
            n_total++;
            if (b !== exp[k]) $display("FAIL read2_byte%0d got %h want %h", k, b, exp[k]);
            else n_pass++;
        end
        n_total++;
        if (fetch_q.size() !== 2) $display("FAIL read2_nfetch got %0d want 2", fetch_q.size());
        else n_pass++;
        n_total++;
        if (fetch_q.size() < 1 || fetch_q[0] !== 32'h0) $display("FAIL read2_fetch0 got %h want 00000000", fetch_q.size() > 0 ? fetch_q[0] : 32'hx);
        else n_pass++;
        n_total++;
        if (fetch_q.size() < 2 || fetch_q[1] !== 32'h4) $display("FAIL read2_fetch1 got %h want 00000004", fetch_q.size() > 1 ? fetch_q[1] : 32'hx);
        else n_pass++;
    endtask

    task automatic test_read_wrap();
        logic [7:0] exp [5] = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h11};
        logic [7:0] b;
        start_txn();
        send_byte(8'h03);
        send_addr(24'hFFFFFC);
        for (int k = 0; k < 5; k++) begin
            read_byte(b);
            n_total++;
            if (b !== exp[k]) $display("FAIL wrap_byte%0d got %h want %h", k, b, exp[k]);
            else n_pass++;
        end
        n_total++;
        if (fetch_q.size() !== 2) $display("FAIL wrap_nfetch got %0d want 2", fetch_q.size());
        else n_pass++;
        n_total++;
        if (fetch_q.size() < 1 || fetch_q[0] !== 32'h00FFFFFC) $display("FAIL wrap_fetch0 got %h want 00fffffc", fetch_q.size() > 0 ? fetch_q[0] : 32'hx);
        else n_pass++;
        n_total++;
        if (fetch_q.size() < 2 || fetch_q[1] !== 32'h0) $display("FAIL wrap_fetch1 got %h want 00000000", fetch_q.size() > 1 ? fetch_q[1] : 32'hx);
        else n_pass++;
    endtask

    task automatic test_fast_read();
        logic [7:0] b;
        start_txn();
        send_byte(8'h0B);
`ifdef FLASH_FAST_READ_EN
        send_addr(24'h000010);
        for (int i = 0; i < 7; i++) begin
            bus.mosi = 1'($urandom_range(0, 1));
            @(negedge clock);
        end
        n_total++;
        if (fetch_q.size() !== 0) $display("FAIL fast_early_fetch got %0d want 0", fetch_q.size());
        else n_pass++;
        bus.mosi = 1'b1;
        @(negedge clock);
        read_byte(b);
        n_total++;
        if (b !== 8'h10) $display("FAIL fast_byte0 got %h want 10", b);
        else n_pass++;
        read_byte(b);
        n_total++;
        if (b !== 8'h11) $display("FAIL fast_byte1 got %h want 11", b);
        else n_pass++;
        n_total++;
        if (fetch_q.size() < 1 || fetch_q[0] !== 32'h10) $display("FAIL fast_fetch0 got %h want 00000010", fetch_q.size() > 0 ? fetch_q[0] : 32'hx);
        else n_pass++;
`else
        send_addr(24'h000010);
        n_total++;
        if (bus.cmd_err !== 1'b1) $display("FAIL fast_off_cmd_err got %b want 1", bus.cmd_err);
        else n_pass++;
        read_byte(b);
        n_total++;
        if (b !== 8'hFF) $display("FAIL fast_off_miso got %h want ff", b);
        else n_pass++;
        n_total++;
        if (fetch_q.size() !== 0) $display("FAIL fast_off_nfetch got %0d want 0", fetch_q.size());
        else n_pass++;
`endif
    endtask

    task automatic test_jedec();
        logic [7:0] exp [5] = '{8'hEF, 8'h40, 8'h18, 8'hFF, 8'hFF};
        logic [7:0] b;
        start_txn();
        send_byte(8'h9F);
        for (int k = 0; k < 5; k++) begin
            read_byte(b);
            n_total++;
            if (b !== exp[k]) $display("FAIL jedec_byte%0d got %h want %h", k, b, exp[k]);
            else n_pass++;
        end
    endtask

    task automatic test_status();
        logic [7:0] b;
        start_txn();
        send_byte(8'h05);
        for (int k = 0; k < 2; k++) begin
            read_byte(b);
            n_total++;
            if (b !== 8'h00) $display("FAIL status_byte%0d got %h want 00", k, b);
            else n_pass++;
        end
    endtask

    task automatic test_err();
        logic [7:0] b;
        start_txn();
        send_byte(8'h02);
        n_total++;
        if (bus.cmd_err !== 1'b1) $display("FAIL err_cmd_err got %b want 1", bus.cmd_err);
        else n_pass++;
        read_byte(b);
        read_byte(b);
        n_total++;
        if (b !== 8'hFF || bus.cmd_err !== 1'b1) $display("FAIL err_stuck got miso %h err %b want ff 1", b, bus.cmd_err);
        else n_pass++;
        n_total++;
        if (fetch_q.size() !== 0) $display("FAIL err_nfetch got %0d want 0", fetch_q.size());
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_total++;
        if (bus.cmd_err !== 1'b0) $display("FAIL err_async_clear got %b want 0", bus.cmd_err);
        else n_pass++;
        @(negedge clock);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        start_txn();
        send_byte(8'h03);
        send_addr(24'h000000);
        read_byte(b);
        for (int i = 0; i < 5; i++) begin
            bus.mosi = 1'b0;
            @(negedge clock);
        end
        #2 reset = 1'b1;
        #1;
        n_total++;
        if (bus.miso !== 1'b1) $display("FAIL midrst_miso got %b want 1", bus.miso);
        else n_pass++;
        n_total++;
        if (bus.cmd_err !== 1'b0) $display("FAIL midrst_cmd_err got %b want 0", bus.cmd_err);
        else n_pass++;
        @(negedge clock);
        // Abort a half-shifted opcode too, then a clean status read must work
        start_txn();
        send_byte(8'hFF);
        start_txn();
        send_byte(8'h05);
        read_byte(b);
        n_total++;
        if (b !== 8'h00) $display("FAIL midrst_status got %h want 00", b);
        else n_pass++;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        reset    = 1'b1;
        bus.mosi = 1'b0;
        @(negedge clock);
        test_reset();
        test_read_aligned();
        test_read_unaligned();
        test_read_wrap();
        test_fast_read();
        test_jedec();
        test_status();
        test_err();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/flash_stream.md
FLASH_STREAM -- requirements
Module: flash_stream

Interface
REQ-001 SHALL have parameter ADDR_BYTES, default 3, address bytes per command (3 or 4).
REQ-002 SHALL have parameter SIZE_LOG2, default 24, log2 of flash size in bytes; read address wraps modulo 2^SIZE_LOG2.
REQ-003 SHALL have parameter DUMMY_CYCLES, default 8, dummy clocks for fast read.
REQ-004 SHALL have parameter JEDEC_ID, default 24'hEF4018, ID bytes returned by 9Fh, MSB byte first.
REQ-005 SHALL have port clock  input  1  SPI SCK; all state updates on posedge.
REQ-006 SHALL have port reset  input  1  SPI SS; asynchronous, active-high; high = deselected.
REQ-007 SHALL have port mosi  input  1  serial in, MSB first, sampled on posedge clock.
REQ-008 SHALL have port miso  output  1  serial out, MSB of each byte first.
REQ-009 SHALL have port cmd_err  output  1  sticky flag for an unsupported opcode in the current transaction.

Function
REQ-010 SHALL implement states CMD, ADDR, DUMMY, DATA, ID, STATUS, ERR.
REQ-011 CMD: SHALL shift 8 opcode bits; on the 8th bit it SHALL transition by opcode:
- 03h -> ADDR
- 0Bh -> ADDR (macro-gated, REQ-024)
- 9Fh -> ID
- 05h -> STATUS
- anything else -> ERR
REQ-012 ADDR: SHALL shift 8*ADDR_BYTES bits; on the last bit it SHALL go to DATA (03h) or DUMMY (0Bh).
REQ-013 DUMMY: SHALL count DUMMY_CYCLES clocks, ignore mosi, then go to DATA; DUMMY_CYCLES=0 SHALL go straight to DATA.
REQ-014 Fetch: SHALL call DPI flash_read(addr, data) with the word-aligned address (low 2 bits zero, upper bits zeroed above SIZE_LOG2) on the posedge that completes the address (03h) or the last dummy clock (0Bh).
REQ-015 Byte mapping: byte at address A SHALL be bits [8*(A%4)+7 : 8*(A%4)] of the returned word.
REQ-016 Start offset: the first byte output SHALL be at the exact start address (unaligned start allowed); bytes below it in that word are skipped.
REQ-017 DATA timing: bit 7 of the first byte SHALL appear on miso immediately after the fetching posedge (zero-clock latency); miso SHALL advance one bit per posedge.
REQ-018 Streaming: after the last bit of byte offset 3, the next word (address + 4, wrapping modulo 2^SIZE_LOG2) SHALL be fetched on the same posedge, with no gap bits; reads continue indefinitely until reset.
REQ-019 ID: SHALL output JEDEC_ID bytes [23:16], [15:8], [7:0], then 8'hFF continuously.
REQ-020 STATUS: SHALL output 8'h00 repeatedly (never busy, never write-enabled).
REQ-021 ERR: miso SHALL be 1 and cmd_err SHALL be 1 until reset; ERR SHALL ignore mosi and SHALL NOT call flash_read.
REQ-022 While reset is high, miso SHALL be 1 regardless of state.

Reset
REQ-023 reset high SHALL asynchronously return state to CMD, clear all counters, opcode, address and data shift registers, and clear cmd_err to 0; miso SHALL be 1; deassertion mid-byte of a prior transaction SHALL start a fresh command.

Configuration
REQ-024 Macro FLASH_FAST_READ_EN: defined -> 0Bh supported per REQ-012/013; undefined -> 0Bh treated as unsupported (ERR, cmd_err=1) and the DUMMY state/counter SHALL be absent.

Verification
REQ-025 03h, addr 000000h, flash_read(0)=32'h44332211 -> miso bytes 11h,22h,33h,44h, then the word at 4 follows with no gap.
REQ-026 03h, addr 000002h -> first bytes 33h,44h, then byte 0 of word 4; flash_read called with 0 then 4.
REQ-027 03h, addr FFFFFCh, SIZE_LOG2=24 -> after 4 bytes the next fetch address is 000000h.
REQ-028 0Bh with FLASH_FAST_READ_EN, DUMMY_CYCLES=8, addr 000010h -> data begins after exactly 8 dummy clocks; without the macro -> cmd_err=1, miso=1.
REQ-029 9Fh -> EFh,40h,18h, then FFh; opcode 02h -> cmd_err=1, miso stuck at 1, no DPI call.
REQ-030 reset pulse mid-data (after bit 13) -> cmd_err=0, miso=1; a new 05h transaction returns 00h.
